// File: rtl/alu_op_sequencer_if.sv
// Bundle of the FIFO_IN pop side, FIFO_OUT push side and ALU issue/complete
// signals seen by alu_op_sequencer.
// master: the sequencer (drives pop/push strobes, ALU operands and start).
// slave:  the surrounding FIFOs and ALU core.
interface alu_op_sequencer_if #(
    parameter int DATA_SIZE      = 8,
    parameter int OPERATION_SIZE = 4,
    parameter int FIFO_IN_WIDTH  = 24,
    parameter int FIFO_OUT_WIDTH = 21
);
    // FIFO_IN (command words)
    logic                        empty_in;
    logic                        r_en_in;
    logic [FIFO_IN_WIDTH-1:0]    fifo_in_data;
    // FIFO_OUT (tagged results)
    logic                        full_out;
    logic                        w_en_out;
    logic [FIFO_OUT_WIDTH-1:0]   fifo_out_wdata;
    // ALU core
    logic                        alu_start;
    logic [OPERATION_SIZE-1:0]   alu_op;
    logic [DATA_SIZE-1:0]        alu_a;
    logic [DATA_SIZE-1:0]        alu_b;
    logic                        alu_done;
    logic [2*DATA_SIZE-1:0]      alu_result;
    logic                        alu_err;

    modport master (
        input  empty_in, fifo_in_data, full_out, alu_done, alu_result, alu_err,
        output r_en_in, w_en_out, fifo_out_wdata, alu_start, alu_op, alu_a, alu_b
    );

    modport slave (
        output empty_in, fifo_in_data, full_out, alu_done, alu_result, alu_err,
        input  r_en_in, w_en_out, fifo_out_wdata, alu_start, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Pops command words, issues them to the ALU, pushes tagged results (or error words).
// Latency: pop->push 3+L cycles (ALU latency L), 2 cycles for an invalid opcode, TIMEOUT_CYCLES+1 after start on timeout.
// Backpressure: holds in PUSH while full_out; pops only when run && !empty_in.
//
// Ports: clk/rst_n (async active-low); run gates new pops; bus (master) carries
// FIFO_IN pop, FIFO_OUT push and ALU issue/completion; busy = not idle;
// op_count counts pushed words (wraps); timeout_count counts timeouts (saturates).
module alu_op_sequencer #(
    parameter int DATA_SIZE      = 8,
    parameter int OPERATION_SIZE = 4,
    parameter int ID_SIZE        = 4,
    parameter int OPERATION_BIT  = 16,
    parameter int ID_BIT         = 20,
    parameter int FIFO_IN_WIDTH  = 24,
    parameter int FIFO_OUT_WIDTH = 21,
    parameter int NUM_OPS        = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 run,
    alu_op_sequencer_if.master   bus,
    output logic                 busy,
    output logic [15:0]          op_count,
    output logic [7:0]           timeout_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        PUSH  = 3'd4
    } state_t;

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0]        TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [OPERATION_SIZE:0]   NUM_OPS_W  = (OPERATION_SIZE + 1)'(NUM_OPS);
    localparam logic [2*DATA_SIZE-1:0]    ZERO_RES   = '0;

    state_t state, state_nxt;

    logic [ID_SIZE-1:0]  id_q;
    logic [TIMER_W-1:0]  timer;

    logic r_en_c, w_en_c, start_c;

    // Command word fields, meaningful in FETCH (the cycle after the pop)
    logic [OPERATION_SIZE-1:0] in_op;
    logic [ID_SIZE-1:0]        in_id;
    logic [DATA_SIZE-1:0]      in_d0;
    logic [DATA_SIZE-1:0]      in_d1;
    logic                      in_invalid;
    logic                      timer_last;
    logic                      can_pop;

    assign in_op      = bus.fifo_in_data[OPERATION_BIT +: OPERATION_SIZE];
    assign in_id      = bus.fifo_in_data[ID_BIT +: ID_SIZE];
    assign in_d0      = bus.fifo_in_data[0 +: DATA_SIZE];
    assign in_d1      = bus.fifo_in_data[DATA_SIZE +: DATA_SIZE];
    assign in_invalid = ({1'b0, in_op} >= NUM_OPS_W);
    assign timer_last = (timer == TIMER_LAST);
    assign can_pop    = run && !bus.empty_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        r_en_c    = 1'b0;
        w_en_c    = 1'b0;
        start_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (can_pop) begin
                    r_en_c    = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = in_invalid ? PUSH : ISSUE;
            end
            ISSUE: begin
                start_c   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.alu_done || timer_last) begin
                    state_nxt = PUSH;
                end
            end
            PUSH: begin
                if (!bus.full_out) begin
                    w_en_c = 1'b1;
                    // Chain straight into the next fetch so streaming costs no idle cycle
                    if (can_pop) begin
                        r_en_c    = 1'b1;
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are forced low while reset is held so nothing pops or pushes
    // from the reset state even with run high and FIFO_IN non-empty.
    assign bus.r_en_in   = r_en_c  & rst_n;
    assign bus.w_en_out  = w_en_c  & rst_n;
    assign bus.alu_start = start_c & rst_n;
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_op         <= '0;
            bus.alu_a          <= '0;
            bus.alu_b          <= '0;
            bus.fifo_out_wdata <= '0;
            id_q               <= '0;
            timer              <= '0;
            op_count           <= '0;
            timeout_count      <= '0;
        end else begin
            unique case (state)
                FETCH: begin
                    // Operands stay untouched until the next FETCH, so they are
                    // stable across ISSUE and WAIT.
                    bus.alu_op <= in_op;
                    bus.alu_a  <= in_d0;
                    bus.alu_b  <= in_d1;
                    id_q       <= in_id;
                    if (in_invalid) begin
                        bus.fifo_out_wdata <= {1'b1, in_id, ZERO_RES};
                    end
                end
                ISSUE: begin
                    timer <= '0;
                end
                WAIT: begin
                    if (bus.alu_done) begin
                        bus.fifo_out_wdata <= {bus.alu_err, id_q, bus.alu_result};
                    end else if (timer_last) begin
                        bus.fifo_out_wdata <= {1'b1, id_q, ZERO_RES};
                        if (timeout_count != 8'hFF) begin
                            timeout_count <= timeout_count + 8'd1;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                PUSH: begin
                    if (!bus.full_out) begin
                        op_count <= op_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        busy;
    logic [15:0] op_count;
    logic [7:0]  timeout_count;

    alu_op_sequencer_if #(
        .DATA_SIZE(8), .OPERATION_SIZE(4), .FIFO_IN_WIDTH(24), .FIFO_OUT_WIDTH(21)
    ) bus ();

    alu_op_sequencer #(
        .DATA_SIZE(8), .OPERATION_SIZE(4), .ID_SIZE(4), .OPERATION_BIT(16), .ID_BIT(20),
        .FIFO_IN_WIDTH(24), .FIFO_OUT_WIDTH(21), .NUM_OPS(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run(run),
        .bus(bus.master),
        .busy(busy),
        .op_count(op_count),
        .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int proto_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Environment: FIFO_IN contents, ALU behaviour, event log
    logic [23:0] in_q[$];
    int          cyc = 0;
    int          alu_cd = -1;
    int          cfg_lat = 1;     // <= 0 : ALU never completes
    logic        cfg_echo = 1'b0; // result = {alu_b, alu_a} captured at start
    logic [15:0] cfg_res = '0;
    logic        cfg_err = 1'b0;
    logic [15:0] cap_ab = '0;
    logic        busy_s = 1'b0;
    int          sample_cyc = 0;

    int          pop_cycs[$];
    int          push_cycs[$];
    int          start_cycs[$];
    logic [20:0] push_words[$];
    logic [19:0] start_ops[$];

    task automatic clear_log();
        pop_cycs.delete();
        push_cycs.delete();
        start_cycs.delete();
        push_words.delete();
        start_ops.delete();
    endtask

    // One clock cycle: sample DUT outputs mid-cycle, then update FIFO/ALU models after the edge.
    task automatic step();
        logic        pop, push, start;
        logic [20:0] wd;
        #1;
        pop   = bus.r_en_in;
        push  = bus.w_en_out;
        start = bus.alu_start;
        wd    = bus.fifo_out_wdata;
        busy_s = busy;
        sample_cyc = cyc;
        if (pop && bus.empty_in) begin
            proto_errs++;
            $display("FAIL pop_on_empty: r_en_in=1 with empty_in=1 at cycle %0d", cyc);
        end
        if (push && bus.full_out) begin
            proto_errs++;
            $display("FAIL push_on_full: w_en_out=1 with full_out=1 at cycle %0d", cyc);
        end
        if (pop)   pop_cycs.push_back(cyc);
        if (push) begin
            push_cycs.push_back(cyc);
            push_words.push_back(wd);
        end
        if (start) begin
            start_cycs.push_back(cyc);
            start_ops.push_back({bus.alu_op, bus.alu_b, bus.alu_a});
            cap_ab = {bus.alu_b, bus.alu_a};
        end
        @(posedge clk);
        #1;
        cyc++;
        if (pop && in_q.size() > 0) bus.fifo_in_data = in_q.pop_front();
        bus.empty_in = (in_q.size() == 0);
        bus.alu_done = 1'b0;
        bus.alu_err  = 1'b0;
        if (start && cfg_lat > 0) alu_cd = cfg_lat;
        if (alu_cd > 0) begin
            alu_cd--;
            if (alu_cd == 0) begin
                bus.alu_done   = 1'b1;
                bus.alu_result = cfg_echo ? cap_ab : cfg_res;
                bus.alu_err    = cfg_err;
                alu_cd = -1;
            end
        end
    endtask

    typedef struct {
        logic [23:0] word;
        int          lat;
        logic [15:0] res;
        logic        err;
        logic [20:0] exp_w;
        int          exp_delta;  // push cycle - pop cycle
        logic        started;
    } vec_t;

    vec_t vecs[6];
    logic [23:0] w;

    initial begin
        vecs[0] = '{24'h31050A, 3, 16'h000F, 1'b0, 21'h03000F, 6,  1'b1}; // single op, L=3
        vecs[1] = '{24'h2A0000, 1, 16'h0000, 1'b0, 21'h120000, 2,  1'b0}; // op A invalid
        vecs[2] = '{24'h97FF01, 1, 16'hABCD, 1'b1, 21'h19ABCD, 4,  1'b1}; // op 7 (last valid), ALU err
        vecs[3] = '{24'hE81234, 1, 16'h0000, 1'b0, 21'h1E0000, 2,  1'b0}; // op 8 (first invalid)
        vecs[4] = '{24'h520304, 0, 16'h0000, 1'b0, 21'h150000, 19, 1'b1}; // timeout
        vecs[5] = '{24'hF00102, 2, 16'h1234, 1'b0, 21'h0F1234, 5,  1'b1}; // op 0, L=2

        // Reset state, with run high and FIFO_IN reporting data
        bus.empty_in = 1'b0;
        bus.fifo_in_data = '0;
        bus.full_out = 1'b0;
        bus.alu_done = 1'b0;
        bus.alu_result = '0;
        bus.alu_err = 1'b0;
        run = 1'b1;
        #12;
        check("rst_r_en_in",   32'(bus.r_en_in), 32'd0);
        check("rst_w_en_out",  32'(bus.w_en_out), 32'd0);
        check("rst_alu_start", 32'(bus.alu_start), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_regs",      32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
        check("rst_wdata",     32'(bus.fifo_out_wdata), 32'd0);
        check("rst_counts",    32'({op_count, timeout_count}), 32'd0);
        bus.empty_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table-driven single transactions
        for (int i = 0; i < 6; i++) begin
            clear_log();
            cfg_lat = vecs[i].lat;
            cfg_res = vecs[i].res;
            cfg_err = vecs[i].err;
            cfg_echo = 1'b0;
            in_q.push_back(vecs[i].word);
            bus.empty_in = 1'b0;
            for (int k = 0; k < 60 && push_cycs.size() == 0; k++) step();
            step();
            step();
            w = vecs[i].word;
            check($sformatf("v%0d_push_count", i), push_cycs.size(), 1);
            if (push_cycs.size() > 0) begin
                check($sformatf("v%0d_wdata", i), 32'(push_words[0]), 32'(vecs[i].exp_w));
                check($sformatf("v%0d_push_lat", i), push_cycs[0] - pop_cycs[0], vecs[i].exp_delta);
            end
            check($sformatf("v%0d_start_count", i), start_cycs.size(), vecs[i].started ? 1 : 0);
            if (vecs[i].started && start_cycs.size() > 0) begin
                check($sformatf("v%0d_start_lat", i), start_cycs[0] - pop_cycs[0], 2);
                check($sformatf("v%0d_operands", i), 32'(start_ops[0]), 32'({w[19:16], w[15:8], w[7:0]}));
            end
        end
        check("table_op_count", 32'(op_count), 32'd6);
        check("table_timeout_count", 32'(timeout_count), 32'd1);

        // Late alu_done after the timeout must be ignored
        clear_log();
        bus.alu_done = 1'b1;
        bus.alu_result = 16'hFFFF;
        bus.alu_err = 1'b1;
        step();
        step();
        check("late_done_push", push_cycs.size(), 0);
        check("late_done_busy", 32'(busy_s), 32'd0);
        check("late_done_timeouts", 32'(timeout_count), 32'd1);

        // Backpressure: FIFO_OUT full throughout PUSH
        clear_log();
        cfg_lat = 1;
        cfg_echo = 1'b1;
        cfg_err = 1'b0;
        bus.full_out = 1'b1;
        in_q.push_back(24'h432211);
        in_q.push_back(24'h610203);
        bus.empty_in = 1'b0;
        cyc = 0;
        for (int k = 0; k < 10; k++) step();   // PUSH held over cycles 4..9
        check("bp_no_push", push_cycs.size(), 0);
        check("bp_no_pop", pop_cycs.size(), 1);
        check("bp_busy", 32'(busy), 32'd1);
        check("bp_wdata_held", 32'(bus.fifo_out_wdata), 32'h042211);
        bus.full_out = 1'b0;
        for (int k = 0; k < 20 && push_cycs.size() < 2; k++) step();
        check("bp_push_count", push_cycs.size(), 2);
        if (push_cycs.size() == 2 && pop_cycs.size() == 2) begin
            check("bp_release_cycle", push_cycs[0], 10);
            check("bp_pop_with_push", pop_cycs[1], 10);
            check("bp_word0", 32'(push_words[0]), 32'h042211);
            check("bp_word1", 32'(push_words[1]), 32'h060203);
            check("bp_second_push", push_cycs[1], 14);
        end
        step();

        // Streaming: four queued words, L=1
        clear_log();
        for (int k = 0; k < 4; k++)
            in_q.push_back({4'(k + 8), 4'(k), 8'(16 * k + 1), 8'(k + 2)});
        bus.empty_in = 1'b0;
        for (int k = 0; k < 60 && push_cycs.size() < 4; k++) step();
        step();
        step();
        check("st_push_count", push_cycs.size(), 4);
        check("st_pop_count", pop_cycs.size(), 4);
        if (push_cycs.size() == 4 && pop_cycs.size() == 4) begin
            for (int k = 0; k < 4; k++)
                check($sformatf("st_word%0d", k), 32'(push_words[k]),
                      32'({1'b0, 4'(k + 8), 8'(16 * k + 1), 8'(k + 2)}));
            for (int k = 0; k < 3; k++) begin
                check($sformatf("st_period%0d", k), push_cycs[k + 1] - push_cycs[k], 4);
                check($sformatf("st_pop_with_push%0d", k), pop_cycs[k + 1], push_cycs[k]);
            end
        end

        // Streaming with run dropped after the second pop
        clear_log();
        for (int k = 0; k < 4; k++) in_q.push_back({4'(k), 4'(2), 16'(k * 257)});
        bus.empty_in = 1'b0;
        for (int k = 0; k < 40 && pop_cycs.size() < 2; k++) step();
        run = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (!busy_s && push_cycs.size() >= 2) break;
        end
        for (int k = 0; k < 4; k++) step();
        check("stop_push_count", push_cycs.size(), 2);
        check("stop_left_in_fifo", in_q.size(), 2);
        if (push_cycs.size() == 2) begin
            check("stop_busy_fall", pop_cycs.size() * 0 + push_cycs[1] + 1, push_cycs[1] + 1 + (busy_s ? 1 : 0));
            check("stop_word1", 32'(push_words[1]), 32'h010101);
        end
        in_q.delete();
        bus.empty_in = 1'b1;

        // Reset asserted while waiting on the ALU
        clear_log();
        cfg_lat = 0;
        run = 1'b1;
        in_q.push_back(24'h7301AA);
        in_q.push_back(24'h7302BB);
        bus.empty_in = 1'b0;
        for (int k = 0; k < 20 && start_cycs.size() == 0; k++) step();
        step();
        step();
        step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_strobes", 32'({bus.r_en_in, bus.w_en_out, bus.alu_start}), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_regs", 32'({bus.alu_op, bus.alu_a, bus.alu_b}), 32'd0);
        check("arst_wdata", 32'(bus.fifo_out_wdata), 32'd0);
        check("arst_counts", 32'({op_count, timeout_count}), 32'd0);
        run = 1'b0;
        alu_cd = -1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        clear_log();
        for (int k = 0; k < 25; k++) step();
        check("post_rst_no_push", push_cycs.size(), 0);
        check("post_rst_op_count", 32'(op_count), 32'd0);

        check("protocol_errors", proto_errs, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Sequences operations through the ALU datapath: pops packed command words from FIFO_IN (written by the APB CSR block), unpacks operation, ID and operands, issues them to the ALU core, and waits for completion or timeout. It then pushes a tagged result word into FIFO_OUT for the CSR block to read back. It sits between the two FIFOs and the ALU core and is the only master of the ALU's start strobe.

## Interface
- DATA_SIZE, 8, operand width; result width is 2*DATA_SIZE
- OPERATION_SIZE, 4, opcode field width
- ID_SIZE, 4, transaction ID field width
- OPERATION_BIT, 16, LSB of opcode field in FIFO_IN word
- ID_BIT, 20, LSB of ID field in FIFO_IN word
- FIFO_IN_WIDTH, 24, FIFO_IN word width: data0 [DATA_SIZE-1:0], data1 [2*DATA_SIZE-1:DATA_SIZE], op, id
- FIFO_OUT_WIDTH, 21, FIFO_OUT word width: result [2*DATA_SIZE-1:0], id [2*DATA_SIZE +: ID_SIZE], err at bit FIFO_OUT_WIDTH-1
- NUM_OPS, 8, opcodes >= NUM_OPS are invalid
- TIMEOUT_CYCLES, 16, max WAIT cycles before forced error completion

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  CSR enable; gates new pops only
- empty_in  in  1  FIFO_IN empty
- r_en_in  out  1  FIFO_IN pop strobe
- fifo_in_data  in  FIFO_IN_WIDTH  valid the cycle after r_en_in
- full_out  in  1  FIFO_OUT full
- w_en_out  out  1  FIFO_OUT push strobe
- fifo_out_wdata  out  FIFO_OUT_WIDTH  result word, registered
- alu_start  out  1  one-cycle issue pulse
- alu_op  out  OPERATION_SIZE  opcode, registered
- alu_a, alu_b  out  DATA_SIZE  data0 / data1, registered
- alu_done  in  1  ALU completion pulse
- alu_result  in  2*DATA_SIZE  valid with alu_done
- alu_err  in  1  ALU error, valid with alu_done
- busy  out  1  state != IDLE
- op_count  out  16  pushed words, wraps
- timeout_count  out  8  timeouts, saturates at 255

## Operation
- States: IDLE, FETCH, ISSUE, WAIT, PUSH.
- IDLE: if run && !empty_in, r_en_in=1, go FETCH.
- FETCH: latch fifo_in_data fields into alu_op/alu_a/alu_b and id register. If op >= NUM_OPS: load fifo_out_wdata={1,id,0}, go PUSH (ALU not started). Else go ISSUE.
- ISSUE: alu_start=1 for exactly this cycle; clear timer; go WAIT. alu_done in ISSUE is ignored.
- WAIT: alu_done=1 -> fifo_out_wdata={alu_err,id,alu_result}, go PUSH. Else timer++; on TIMEOUT_CYCLES-th WAIT cycle without done: fifo_out_wdata={1,id,0}, timeout_count++ (saturating), go PUSH. Late alu_done after timeout is ignored.
- PUSH: while full_out, hold (w_en_out=0). When !full_out: w_en_out=1, op_count++; then if run && !empty_in, r_en_in=1 same cycle, go FETCH; else go IDLE.
- alu_op/alu_a/alu_b stable from ISSUE through exit of WAIT.
- run deassert mid-operation: current op completes and is pushed; no further pops.
- r_en_in, w_en_out, alu_start decoded combinationally from state and inputs; never asserted when empty_in / full_out respectively.

## Timing
- Reset: state IDLE; every output 0 (r_en_in, w_en_out, alu_start, busy, alu_op, alu_a, alu_b, fifo_out_wdata, op_count, timeout_count, timer).
- Reset mid-operation aborts immediately; in-flight word is lost, nothing pushed.
- Valid op, ALU latency L>=1 cycles after alu_start, FIFO_OUT not full: pop at cycle 0, alu_start cycle 2, done cycle 2+L, w_en_out cycle 3+L.
- Back-to-back: next pop coincides with previous push; period L+3 cycles.
- Invalid op: pop cycle 0, w_en_out cycle 2.
- Timeout: w_en_out TIMEOUT_CYCLES+1 cycles after alu_start.

## Test plan
- Single op: fifo_in_data=24'h31050A, alu_done+alu_result=16'h000F 3 cycles after alu_start -> alu_op=1, alu_a=0x0A, alu_b=0x05, one w_en_out with fifo_out_wdata=21'h03000F, op_count=1.
- Invalid op: word op=4'hA id=2 -> no alu_start, push 21'h120000 at cycle 2, timeout_count=0.
- Timeout: id=5 valid op, alu_done never -> push 21'h150000 17 cycles after alu_start, timeout_count=1; later alu_done ignored.
- Backpressure: full_out=1 during PUSH for 5 cycles -> no w_en_out, no pop, data held; single push on first cycle full_out=0.
- Streaming: 4 words queued, run=1, L=1 -> pushes every 4 cycles, pop coincident with each push except last; run=0 after 2nd pop -> exactly 2 pushes, busy falls after 2nd push.
- Reset: assert rst_n=0 during WAIT -> all outputs 0 asynchronously, no push after release.
